// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit,
// data/ack back from memory.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/instr_fetch_unit.sv
// Multi-cycle RV32I fetch stage: owns the PC, fetches over req/ack, holds the
// instruction for execute, picks the next PC at retire, counts retirements.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_unit_if.master        imem,
  input  logic                      pc_src,
  input  logic                      jump,
  input  logic [31:0]               target_addr,
  input  logic                      retire,
  output logic [31:0]               instr,
  output logic [6:0]                op,
  output logic [2:0]                funct3,
  output logic                      funct7,
  output logic [6:0]                funct77,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic                      instr_valid,
  output logic                      fetch_err,
  output logic [31:0]               instret
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        err_q, err_d;
  logic [31:0] next_target;
  logic        req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instret_d   = instret_q;
    err_d       = err_q;
    req         = 1'b0;
    instr_valid = 1'b0;
    next_target = (pc_src | jump) ? target_addr : pc_plus4;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (retire) begin
          instret_d = instret_q + 32'd1;
          // A misaligned target halts with pc left at the faulting instruction.
          if (next_target[1:0] != 2'b00) begin
            err_d   = 1'b1;
            instr_d = NOP_INSTR;
            state_d = S_ERR;
          end else begin
            pc_d    = next_target;
            state_d = S_REQ;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign op             = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7         = instr_q[30];
  assign funct77        = instr_q[31:25];
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign fetch_err      = err_q;
  assign instret        = instret_q;

endmodule
